// File: rtl/sdram_read.sv
// SDRAM full-row read-burst sub-controller: ACT, BURST_LEN-spaced READs, PRE, with refresh yield.
// Optional data-pattern checker enabled by defining SDRAM_RD_CHECK_EN.
module sdram_read #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CAS_LAT   = 3,
    parameter int unsigned ROW_MAX   = 4095,
    parameter int unsigned TRP_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_trig,
    input  logic        rd_en,
    input  logic        ref_req,
    input  logic [15:0] sdram_dq_in,
    output logic        rd_req,
    output logic        rd_end,
    output logic [3:0]  rd_cmd,
    output logic [11:0] rd_addr,
    output logic [1:0]  rd_bank,
    output logic [15:0] rd_data,
    output logic        rd_data_vld,
    output logic        rd_err
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned COL_W  = 9;
    localparam int unsigned ROW_W  = 12;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DQ_W   = 16;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACT,
        S_RCD,
        S_RD,
        S_WAIT,
        S_PRE,
        S_TRP
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [COL_W-1:0]    col_cnt;
    logic [ROW_W-1:0]    row_cnt;
    logic                rd_pending;
    logic                row_done;
    logic                issue_rd;
    logic                end_nxt;
    logic                req_nxt;
    logic [3:0]          cmd_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [CAS_LAT-1:0]  vld_dly;

    assign rd_bank = 2'b00;

    // Next-state and look-ahead command decode; outputs are registered from next state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        row_done  = 1'b0;
        end_nxt   = 1'b0;
        issue_rd  = 1'b0;
        cmd_nxt   = CMD_NOP;
        addr_nxt  = '0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (rd_pending) state_nxt = S_REQ;
            end
            S_REQ: begin
                cnt_nxt = '0;
                if (rd_en) state_nxt = S_ACT;
            end
            S_ACT: state_nxt = S_RCD;
            S_RCD: state_nxt = S_RD;
            S_RD: begin
                if (cnt == CNT_W'(BURST_LEN - 1)) begin
                    cnt_nxt = '0;
                    if (col_cnt == '0) begin
                        row_done  = 1'b1;
                        state_nxt = S_WAIT;
                    end else if (ref_req) begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: if (cnt == CNT_W'(CAS_LAT)) state_nxt = S_PRE;
            S_PRE: state_nxt = S_TRP;
            S_TRP: begin
                if (cnt == CNT_W'(TRP_CYC - 1)) begin
                    state_nxt = S_IDLE;
                    end_nxt   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt != state) cnt_nxt = '0;

        case (state_nxt)
            S_ACT: begin
                cmd_nxt  = CMD_ACT;
                addr_nxt = ADDR_W'(row_cnt);
            end
            S_RD: begin
                if (cnt_nxt == '0) begin
                    cmd_nxt  = CMD_READ;
                    addr_nxt = {3'b000, col_cnt};
                    issue_rd = 1'b1;
                end
            end
            S_PRE: begin
                cmd_nxt  = CMD_PRE;
                addr_nxt = 12'h400;
            end
            default: ;
        endcase

        req_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rd_cmd  <= CMD_NOP;
            rd_addr <= '0;
            rd_req  <= 1'b0;
            rd_end  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rd_cmd  <= cmd_nxt;
            rd_addr <= addr_nxt;
            rd_req  <= req_nxt;
            rd_end  <= end_nxt;
        end
    end

    // Row/column position survives a refresh exit so the next grant resumes mid-row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (issue_rd) col_cnt <= col_cnt + COL_W'(BURST_LEN);
            if (row_done) begin
                row_cnt    <= (row_cnt == ROW_W'(ROW_MAX)) ? '0 : row_cnt + ROW_W'(1);
                rd_pending <= 1'b0;
            end else if (rd_trig && (state == S_IDLE) && !rd_pending) begin
                rd_pending <= 1'b1;
            end
        end
    end

    // Every S_RD cycle maps to one data word CAS_LAT cycles later on DQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_dly     <= '0;
            rd_data_vld <= 1'b0;
            rd_data     <= '0;
        end else begin
            vld_dly     <= (vld_dly << 1) | CAS_LAT'(state == S_RD);
            rd_data_vld <= vld_dly[CAS_LAT-1];
            rd_data     <= DQ_W'(sdram_dq_in);
        end
    end

`ifdef SDRAM_RD_CHECK_EN
    logic [DQ_W-1:0] exp_word;

    // Incrementing-pattern checker matching the write sub-controller's data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_word <= '0;
            rd_err   <= 1'b0;
        end else if (rd_data_vld) begin
            exp_word <= exp_word + DQ_W'(1);
            if (rd_data != exp_word) rd_err <= 1'b1;
        end
    end
`else
    assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_read.sv
// Scoreboard bench for sdram_read: expected commands/words queued at trigger time, popped by a monitor.
module tb_sdram_read;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] READ = 4'b0101;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam int CL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rd_trig = 1'b0;
    logic        rd_en;
    logic        ref_req = 1'b0;
    logic [15:0] sdram_dq_in = 16'h0;
    logic        rd_req, rd_end, rd_data_vld, rd_err;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;
    logic [15:0] rd_data;

    always #10 clk = ~clk;
    assign rd_en = rd_req;

    sdram_read #(.ROW_MAX(2)) dut (
        .clk(clk), .rst_n(rst_n), .rd_trig(rd_trig), .rd_en(rd_en), .ref_req(ref_req),
        .sdram_dq_in(sdram_dq_in), .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd),
        .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_data(rd_data),
        .rd_data_vld(rd_data_vld), .rd_err(rd_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [17:0] cmd_q[$];
    logic [15:0] data_q[$];

    int act_cyc, first_rd_cyc, first_vld_cyc, w37_cyc, err_cyc;
    int vld_idx, cur_run, max_run, end_cnt, req_cnt, t0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SDRAM model: row contents are base + column, optional corruption of column 37
    logic [15:0] ring[16];
    logic [15:0] row_base[3];
    int  model_row = 0;
    bit  corrupt_en = 1'b0;

    always @(negedge clk) begin
        sdram_dq_in = ring[cyc % 16];
        if (rd_cmd == ACT) model_row = int'(rd_addr);
        if (rd_cmd == READ && model_row < 3) begin
            for (int k = 0; k < 4; k++) begin
                int col;
                logic [15:0] v;
                col = int'(rd_addr[8:0]) + k;
                v = row_base[model_row] + 16'(col);
                if (corrupt_en && col == 37) v = ~v;
                ring[(cyc + CL + k) % 16] = v;
            end
        end
    end

    // Monitor: pop and compare whenever the DUT issues a command or a valid word
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_cmd != NOP) begin
                if (rd_cmd == ACT) act_cyc = cyc;
                if (rd_cmd == READ && first_rd_cyc < 0) first_rd_cyc = cyc;
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: actual cmd=%b addr=0x%0h, expected no command", rd_cmd, rd_addr);
                end else begin
                    check("cmd", 32'({rd_cmd, rd_bank, rd_addr}), 32'(cmd_q.pop_front()));
                end
            end
            if (rd_data_vld) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (vld_idx == 37) w37_cyc = cyc;
                vld_idx++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                if (data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data: actual=0x%0h, expected no word", rd_data);
                end else begin
                    check("data", 32'(rd_data), 32'(data_q.pop_front()));
                end
            end else begin
                cur_run = 0;
            end
            if (rd_end) end_cnt++;
            if (rd_err && err_cyc < 0) err_cyc = cyc;
            if (rd_req) req_cnt++;
        end
    end

    task automatic new_phase();
        act_cyc = -1; first_rd_cyc = -1; first_vld_cyc = -1; w37_cyc = -1; err_cyc = -1;
        vld_idx = 0; cur_run = 0; max_run = 0; end_cnt = 0; req_cnt = 0;
    endtask

    task automatic push_row(input int row, input int c0, input int c1, input int base, input bit corrupt);
        cmd_q.push_back({ACT, 2'b00, 12'(row)});
        for (int c = c0; c <= c1; c += 4) cmd_q.push_back({READ, 2'b00, 12'(c)});
        cmd_q.push_back({PRE, 2'b00, 12'h400});
        for (int c = c0; c <= c1 + 3; c++) begin
            logic [15:0] v;
            v = 16'(base + c);
            if (corrupt && c == 37) v = ~v;
            data_q.push_back(v);
        end
    endtask

    task automatic trig();
        @(posedge clk); #1;
        t0 = cyc;
        rd_trig = 1'b1;
        @(posedge clk); #1;
        rd_trig = 1'b0;
        check("req_t0p1", 32'(rd_req), 32'd0);
        @(posedge clk); #1;
        check("req_t0p2", 32'(rd_req), 32'd1);
    endtask

    task automatic wait_end(input int n, input int budget);
        int k = 0;
        while (end_cnt < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("rd_end_seen", 32'(end_cnt >= n), 32'd1);
    endtask

    task automatic wait_read(input int col, input int budget);
        int k = 0;
        bit found = 1'b0;
        while (!found && k < budget) begin
            @(negedge clk);
            k++;
            if (rd_cmd == READ && rd_addr == 12'(col)) found = 1'b1;
        end
        check("read_col_seen", 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ring[i] = 16'h0;
        row_base[0] = 16'd0; row_base[1] = 16'd512; row_base[2] = 16'd1024;
        new_phase();
        #5 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", 32'(rd_cmd), 32'(NOP));
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_req", 32'(rd_req), 32'd0);
        check("rst_end", 32'(rd_end), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_vld", 32'(rd_data_vld), 32'd0);
        check("rst_err", 32'(rd_err), 32'd0);
        check("rst_bank", 32'(rd_bank), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Idle with no trigger: monitor flags any command, request must stay low
        repeat (1000) @(posedge clk);
        check("idle_req_cycles", 32'(req_cnt), 32'd0);

        // Full row 0
        new_phase();
        push_row(0, 0, 508, 0, 1'b0);
        trig();
        wait_end(1, 800);
        check("act_latency", 32'(act_cyc - t0), 32'd3);
        check("first_read_latency", 32'(first_rd_cyc - t0), 32'd5);
        check("read_to_vld", 32'(first_vld_cyc - first_rd_cyc), 32'd4);
        check("vld_run", 32'(max_run), 32'd512);
        check("words", 32'(vld_idx), 32'd512);
        repeat (5) @(posedge clk);
        #1;
        check("end_pulses", 32'(end_cnt), 32'd1);
        check("req_after_end", 32'(rd_req), 32'd0);
        check("cmd_q_empty_a", 32'(cmd_q.size()), 32'd0);
        check("data_q_empty_a", 32'(data_q.size()), 32'd0);
        check("err_a", 32'(rd_err), 32'd0);

        // Row 1 interrupted by refresh at column 200, resumed at 204
        new_phase();
        push_row(1, 0, 200, 512, 1'b0);
        push_row(1, 204, 508, 512, 1'b0);
        trig();
        wait_read(200, 400);
        ref_req = 1'b1;
        wait_end(1, 100);
        ref_req = 1'b0;
        wait_end(2, 800);
        repeat (5) @(posedge clk);
        #1;
        check("end_pulses_b", 32'(end_cnt), 32'd2);
        check("words_b", 32'(vld_idx), 32'd512);
        check("cmd_q_empty_b", 32'(cmd_q.size()), 32'd0);
        check("data_q_empty_b", 32'(data_q.size()), 32'd0);
        check("err_b", 32'(rd_err), 32'd0);

        // Row 2 = ROW_MAX, counter wraps afterwards
        new_phase();
        push_row(2, 0, 508, 1024, 1'b0);
        trig();
        wait_end(1, 800);
        repeat (5) @(posedge clk);
        check("cmd_q_empty_c", 32'(cmd_q.size()), 32'd0);
        check("vld_run_c", 32'(max_run), 32'd512);

        // Wrapped row 0, preloaded to continue the pattern, word 37 corrupted
        new_phase();
        row_base[0] = 16'd1536;
        corrupt_en = 1'b1;
        push_row(0, 0, 508, 1536, 1'b1);
        trig();
        wait_end(1, 800);
        repeat (5) @(posedge clk);
        #1;
        corrupt_en = 1'b0;
        check("cmd_q_empty_d", 32'(cmd_q.size()), 32'd0);
        check("data_q_empty_d", 32'(data_q.size()), 32'd0);
`ifdef SDRAM_RD_CHECK_EN
        check("err_set", 32'(rd_err), 32'd1);
        check("err_rise_cycle", 32'(err_cyc - w37_cyc), 32'd1);
`else
        check("err_tied_low", 32'(rd_err), 32'd0);
`endif

        // Asynchronous reset during S_RD
        new_phase();
        push_row(1, 0, 508, 512, 1'b0);
        trig();
        wait_read(40, 100);
        check("vld_before_rst", 32'(rd_data_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cmd", 32'(rd_cmd), 32'(NOP));
        check("rst_mid_vld", 32'(rd_data_vld), 32'd0);
        check("rst_mid_req", 32'(rd_req), 32'd0);
        check("rst_mid_err", 32'(rd_err), 32'd0);
        cmd_q.delete();
        data_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_hold_cmd", 32'(rd_cmd), 32'(NOP));
        end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // After reset the row counter restarts at 0 and the checker restarts its pattern
        new_phase();
        row_base[0] = 16'd0;
        push_row(0, 0, 508, 0, 1'b0);
        trig();
        wait_end(1, 800);
        repeat (5) @(posedge clk);
        #1;
        check("cmd_q_empty_f", 32'(cmd_q.size()), 32'd0);
        check("data_q_empty_f", 32'(data_q.size()), 32'd0);
        check("vld_run_f", 32'(max_run), 32'd512);
        check("err_f", 32'(rd_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_read.md
# sdram_read

Read-burst sub-controller inside `sdram_top`, the counterpart of the existing write sub-controller. A `rd_trig` pulse requests the arbiter for SDRAM ownership, then the block reads one full row (512 words) with ACTIVE, repeated READ bursts and PRECHARGE commands. It captures `sdram_dq` after the CAS latency and presents the words as a valid-qualified stream. It yields to auto-refresh at burst boundaries and resumes at the saved column.

## Interface
- `BURST_LEN`, 4: words per READ command, mode-register programmed; power of 2.
- `CAS_LAT`, 3: CAS latency in clocks, mode-register programmed.
- `ROW_MAX`, 4095: last row index; the row counter wraps to 0 after it.
- `TRP_CYC`, 2: NOP cycles after PRECHARGE before `rd_end`.
- `clk` in 1: 50 MHz system clock, the same clock as `sdram_clk`.
- `rst_n` in 1: asynchronous active-low reset.
- `rd_trig` in 1: one-cycle read request; sticky until the row completes.
- `rd_en` in 1: arbiter grant, level.
- `ref_req` in 1: refresh pending from the refresh block.
- `sdram_dq_in` in 16: DQ bus input.
- `rd_req` out 1: ownership request to the arbiter.
- `rd_end` out 1: one-cycle pulse when the block releases the bus.
- `rd_cmd` out 4: {cs_n, ras_n, cas_n, we_n}.
- `rd_addr` out 12: row or column address.
- `rd_bank` out 2: constant 2'b00.
- `rd_data` out 16: captured read word.
- `rd_data_vld` out 1: `rd_data` valid.
- `rd_err` out 1: sticky data-check error (see Configuration).

## Operation
- Commands: NOP 4'b0111, ACT 4'b0011, READ 4'b0101, PRE 4'b0010. During PRE, `rd_addr[10]`=1 (all banks).
- `rd_pending` is set by `rd_trig` and cleared when column 511 of the current row has been read.
- States: S_IDLE, S_REQ, S_ACT, S_RCD, S_RD, S_WAIT, S_PRE, S_TRP.
- S_IDLE -> S_REQ when `rd_pending`=1. In S_REQ, `rd_req`=1; go to S_ACT on `rd_en`=1.
- S_ACT: 1 cycle. Issue ACT, `rd_addr`=`row_cnt`. Then S_RCD.
- S_RCD: 1 NOP cycle. Then S_RD.
- S_RD: issue READ with `rd_addr`={3'b0, `col_cnt`} on the first cycle of each BURST_LEN-cycle slot, NOP otherwise. `col_cnt` advances by BURST_LEN per READ.
- Leave S_RD at the end of a slot when `col_cnt` wraps to 0 (row complete) or when `ref_req`=1. An in-progress burst is always finished.
- S_WAIT: CAS_LAT+1 NOP cycles to drain in-flight data. Then S_PRE.
- S_PRE: 1 cycle, issue PRE. Then S_TRP.
- S_TRP: TRP_CYC NOP cycles. At the end, pulse `rd_end`, drop `rd_req`, go to S_IDLE.
- Row complete: `row_cnt` increments (ROW_MAX -> 0) and `rd_pending` clears.
- Refresh exit: `col_cnt` is kept and `rd_pending` stays set, so the next grant resumes at the saved column of the same row.
- `rd_trig` while already pending or busy is ignored; there is no queueing.
- `rd_en` deasserting outside S_REQ is ignored. Once granted, the sequence runs to S_TRP.

## Timing
- Reset values: state S_IDLE; `rd_cmd`=4'b0111; `rd_addr`=0; `rd_req`=0; `rd_end`=0; `rd_data`=0; `rd_data_vld`=0; `rd_err`=0; `row_cnt`=0; `col_cnt`=0; `rd_pending`=0.
- All outputs are registered.
- `rd_trig` at cycle 0 gives `rd_req`=1 at cycle 2.
- `rd_en` high at cycle g gives ACT on `rd_cmd` at g+1 and the first READ at g+3.
- For a READ presented during cycle t, `rd_data_vld`=1 for cycles t+CAS_LAT+1 through t+CAS_LAT+BURST_LEN. `rd_data` is `sdram_dq_in` registered.
- An uninterrupted row is 128 READs over 512 cycles, so `rd_data_vld` stays high for 512 consecutive cycles.
- Asynchronous reset mid-burst returns everything to reset values at once; no PRE is issued.

## Configuration
- `SDRAM_RD_CHECK_EN` defined: compare each valid word against a 16-bit expected counter that starts at 0 and increments per valid word, matching the write pattern. Any mismatch sets `rd_err` until reset.
- Undefined: no checker logic; `rd_err` is tied to 0.

## Test plan
- Reset released, no trigger for 1000 cycles: `rd_cmd`=4'b0111 throughout, `rd_req`=0.
- Init done, then `rd_trig` at 210 us with `rd_en` looped from `rd_req`: ACT row 0, READs at columns 0, 4, …, 508. 512 valid words arrive 4 cycles after each READ (CL=3), then PRE with A10=1 and `rd_end` pulses once.
- Model preloaded with words 0..511 and `SDRAM_RD_CHECK_EN` defined: `rd_data` equals 0..511 in order and `rd_err`=0. Corrupt word 37: `rd_err` rises the cycle after word 37 is valid.
- `ref_req` asserted mid-row at column 200: burst 200–203 completes, then PRE and `rd_end`. The next grant issues ACT row 0 and READ column 204.
- `row_cnt`=4095 at completion: the next trigger activates row 0.
- `rst_n` pulled low during S_RD: `rd_cmd`=NOP and `rd_data_vld`=0 immediately, with no further commands.
